// File: rtl/lcd_ctrl_param.sv
`default_nettype none
// ============================================================================
// lcd_ctrl_param : streams a WIN x WIN fit/zoom/mirror view of a loaded raster
// Revision 1.0
// ============================================================================
module lcd_ctrl_param #(
   parameter int DW    = 8,
   parameter int IMG_W = 12,
   parameter int IMG_H = 9,
   parameter int WIN   = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    cmd,
   input  logic          cmd_valid,
   input  logic [DW-1:0] datain,
   output logic [DW-1:0] dataout,
   output logic          output_valid,
   output logic          busy
);

   localparam int NPIX   = IMG_W * IMG_H;
   localparam int AW     = (NPIX  > 1) ? $clog2(NPIX)  : 1;
   localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int WW     = (WIN   > 1) ? $clog2(WIN)   : 1;
   localparam int SX     = IMG_W / WIN;
   localparam int SY     = IMG_H / WIN;
   localparam int OX_MAX = IMG_W - WIN;
   localparam int OY_MAX = IMG_H - WIN;
   localparam int OX_CTR = (IMG_W - WIN + 1) / 2;
   localparam int OY_CTR = (IMG_H - WIN + 1) / 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_OUT  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   localparam logic [2:0] CMD_LOAD  = 3'd0;
   localparam logic [2:0] CMD_ZIN   = 3'd1;
   localparam logic [2:0] CMD_FIT   = 3'd2;
   localparam logic [2:0] CMD_RIGHT = 3'd3;
   localparam logic [2:0] CMD_LEFT  = 3'd4;
   localparam logic [2:0] CMD_UP    = 3'd5;
   localparam logic [2:0] CMD_DOWN  = 3'd6;
   localparam logic [2:0] CMD_MIR   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic          zoom_q, mirror_q, loaded_q, valid_q;
   logic [XW-1:0] ox_q;
   logic [YW-1:0] oy_q;
   logic [AW-1:0] pix_q;
   logic [WW-1:0] row_q, col_q;
   logic [DW-1:0] dout_q;
   logic [DW-1:0] mem_q [NPIX];

   logic          accept, emit, last_pix, last_out;
   logic [WW-1:0] col_eff;
   logic [AW-1:0] x, y, addr;

   assign last_pix = (pix_q == AW'(NPIX - 1));
   assign last_out = (row_q == WW'(WIN - 1)) && (col_q == WW'(WIN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_d = (cmd == CMD_LOAD) ? S_LOAD : S_CALC;
         S_LOAD:  if (last_pix) state_d = S_CALC;
         S_CALC:  state_d = loaded_q ? S_OUT : S_IDLE;
         S_OUT:   if (last_out) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      accept = (state_q == S_IDLE) && cmd_valid;
      emit   = (state_q == S_OUT);
   end

   // Mirror only reverses the emission order within a row, not the sampled columns.
   always_comb begin
      col_eff = mirror_q ? (WW'(WIN - 1) - col_q) : col_q;
      if (zoom_q) begin
         x = AW'(ox_q) + AW'(col_eff);
         y = AW'(oy_q) + AW'(row_q);
      end else begin
         x = AW'(SX / 2) + AW'(col_eff) * AW'(SX);
         y = AW'(SY / 2) + AW'(row_q) * AW'(SY);
      end
      addr = y * AW'(IMG_W) + x;
   end

   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) mem_q[pix_q] <= datain;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zoom_q   <= 1'b0;
         mirror_q <= 1'b0;
         loaded_q <= 1'b0;
         ox_q     <= '0;
         oy_q     <= '0;
         pix_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         valid_q  <= 1'b0;
         dout_q   <= '0;
      end else begin
         if (accept) begin
            case (cmd)
               CMD_LOAD:  pix_q <= '0;
               CMD_ZIN: begin
                  zoom_q <= 1'b1;
                  ox_q   <= XW'(OX_CTR);
                  oy_q   <= YW'(OY_CTR);
               end
               CMD_FIT:   zoom_q <= 1'b0;
               CMD_RIGHT: if (zoom_q && ox_q < XW'(OX_MAX)) ox_q <= ox_q + XW'(1);
               CMD_LEFT:  if (zoom_q && ox_q != '0)         ox_q <= ox_q - XW'(1);
               CMD_UP:    if (zoom_q && oy_q != '0)         oy_q <= oy_q - YW'(1);
               CMD_DOWN:  if (zoom_q && oy_q < YW'(OY_MAX)) oy_q <= oy_q + YW'(1);
               CMD_MIR:   mirror_q <= ~mirror_q;
               default:   ;
            endcase
         end
         if (state_q == S_LOAD) begin
            pix_q <= pix_q + AW'(1);
            if (last_pix) begin
               loaded_q <= 1'b1;
               zoom_q   <= 1'b0;
               mirror_q <= 1'b0;
               ox_q     <= '0;
               oy_q     <= '0;
            end
         end
         if (state_q == S_CALC) begin
            row_q <= '0;
            col_q <= '0;
         end
         if (emit) begin
            if (col_q == WW'(WIN - 1)) begin
               col_q <= '0;
               row_q <= row_q + WW'(1);
            end else begin
               col_q <= col_q + WW'(1);
            end
            dout_q <= mem_q[addr];
         end
         valid_q <= emit;
      end
   end

   assign dataout      = dout_q;
   assign output_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_param.sv
`default_nettype none
// ============================================================================
// tb_lcd_ctrl_param : random and directed checks of two controller geometries
// Revision 1.0
// ============================================================================
module tb_lcd_ctrl_param;

   localparam int W0 = 12, H0 = 9,  N0 = 4;
   localparam int W1 = 16, H1 = 16, N1 = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] cmd0, cmd1;
   logic       cv0, cv1;
   logic [7:0] din0, din1, dout0, dout1;
   logic       ov0, ov1, busy0, busy1;

   always #5 clk = ~clk;

   lcd_ctrl_param #(.DW(8), .IMG_W(W0), .IMG_H(H0), .WIN(N0)) dut0 (
      .clk(clk), .reset(reset), .cmd(cmd0), .cmd_valid(cv0), .datain(din0),
      .dataout(dout0), .output_valid(ov0), .busy(busy0));

   lcd_ctrl_param #(.DW(8), .IMG_W(W1), .IMG_H(H1), .WIN(N1)) dut1 (
      .clk(clk), .reset(reset), .cmd(cmd1), .cmd_valid(cv1), .datain(din1),
      .dataout(dout1), .output_valid(ov1), .busy(busy1));

   int n_chk  = 0;
   int n_fail = 0;

   int gw[2]   = '{W0, W1};
   int gh[2]   = '{H0, H1};
   int gwin[2] = '{N0, N1};
   int img[2][256];
   bit m_loaded[2], m_zoom[2], m_mir[2];
   int m_ox[2], m_oy[2];
   int got[$];

   function automatic logic rd_valid(input int s);
      return (s != 0) ? ov1 : ov0;
   endfunction
   function automatic logic rd_busy(input int s);
      return (s != 0) ? busy1 : busy0;
   endfunction
   function automatic int rd_data(input int s);
      return (s != 0) ? int'(dout1) : int'(dout0);
   endfunction

   task automatic drive(input int s, input logic v, input logic [2:0] c, input logic [7:0] d);
      if (s == 0) begin cv0 = v; cmd0 = c; din0 = d; end
      else        begin cv1 = v; cmd1 = c; din1 = d; end
   endtask

   function automatic void model_reset(input int s);
      m_loaded[s] = 0; m_zoom[s] = 0; m_mir[s] = 0; m_ox[s] = 0; m_oy[s] = 0;
   endfunction

   function automatic void model_cmd(input int s, input int c);
      case (c)
         0: begin m_loaded[s] = 1; m_zoom[s] = 0; m_mir[s] = 0; m_ox[s] = 0; m_oy[s] = 0; end
         1: begin m_zoom[s] = 1; m_ox[s] = (gw[s] - gwin[s] + 1) / 2; m_oy[s] = (gh[s] - gwin[s] + 1) / 2; end
         2: m_zoom[s] = 0;
         3: if (m_zoom[s] && m_ox[s] < gw[s] - gwin[s]) m_ox[s]++;
         4: if (m_zoom[s] && m_ox[s] > 0) m_ox[s]--;
         5: if (m_zoom[s] && m_oy[s] > 0) m_oy[s]--;
         6: if (m_zoom[s] && m_oy[s] < gh[s] - gwin[s]) m_oy[s]++;
         default: m_mir[s] = !m_mir[s];
      endcase
   endfunction

   function automatic int exp_pix(input int s, input int k);
      int r, c, x, y, sx, sy;
      r = k / gwin[s];
      c = k % gwin[s];
      if (m_mir[s]) c = gwin[s] - 1 - c;
      sx = gw[s] / gwin[s];
      sy = gh[s] / gwin[s];
      if (m_zoom[s]) begin x = m_ox[s] + c; y = m_oy[s] + r; end
      else begin x = sx / 2 + c * sx; y = sy / 2 + r * sy; end
      return img[s][y * gw[s] + x];
   endfunction

   // Issues one command and checks every cycle until busy drops; noise pulses
   // cmd_valid while busy, which must be ignored.
   task automatic run_cmd(input int s, input int c, input bit noise, input string tag);
      int m, n, base, end_k, last;
      bit ev, eb;
      m = gw[s] * gh[s];
      n = gwin[s] * gwin[s];
      model_cmd(s, c);
      base  = (c == 0) ? m : 0;
      end_k = m_loaded[s] ? base + n + 2 : 1;
      last  = -1;
      got.delete();
      @(negedge clk);
      drive(s, 1'b1, 3'(c), 8'd0);
      @(posedge clk);
      for (int k = 0; k <= end_k; k++) begin
         @(negedge clk);
         ev = m_loaded[s] && k >= base + 2 && k <= base + n + 1;
         eb = (k < end_k);
         n_chk++;
         if (rd_valid(s) !== ev) begin
            n_fail++;
            $display("FAIL %s valid k=%0d: got %b expected %b", tag, k, rd_valid(s), ev);
         end
         n_chk++;
         if (rd_busy(s) !== eb) begin
            n_fail++;
            $display("FAIL %s busy k=%0d: got %b expected %b", tag, k, rd_busy(s), eb);
         end
         if (ev && rd_valid(s) === 1'b1) begin
            got.push_back(rd_data(s));
            last = exp_pix(s, k - base - 2);
            n_chk++;
            if (rd_data(s) !== last) begin
               n_fail++;
               $display("FAIL %s pixel %0d: got %0d expected %0d", tag, k - base - 2, rd_data(s), last);
            end
         end
         drive(s, noise && (k < end_k), 3'($urandom_range(0, 7)),
               (c == 0 && k < m) ? 8'(img[s][k]) : 8'($urandom));
      end
      if (last >= 0) begin
         n_chk++;
         if (rd_data(s) !== last) begin
            n_fail++;
            $display("FAIL %s hold: got %0d expected %0d", tag, rd_data(s), last);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 1'b0, 3'd0, 8'd0);
      drive(1, 1'b0, 3'd0, 8'd0);
      repeat (3) @(negedge clk);
      n_chk++;
      if (ov0 !== 1'b0 || busy0 !== 1'b0 || dout0 !== 8'd0 || ov1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got ov=%b busy=%b dout=%0d expected 0 0 0", ov0, busy0, dout0);
      end
      reset = 1'b0;
      model_reset(0);
      model_reset(1);
   endtask

   task automatic test_no_load();
      run_cmd(0, 1, 0, "noload_zin");
      run_cmd(0, 7, 0, "noload_mir");
      run_cmd(0, 3, 0, "noload_right");
   endtask

   task automatic test_load();
      int fit_exp[16] = '{13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94};
      for (int i = 0; i < W0 * H0; i++) img[0][i] = i;
      run_cmd(0, 0, 0, "load_ramp");
      n_chk++;
      if (got.size() != 16) begin
         n_fail++;
         $display("FAIL load_count: got %0d expected 16", got.size());
      end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== fit_exp[i]) begin
            n_fail++;
            $display("FAIL load_fit[%0d]: got %0d expected %0d", i, got[i], fit_exp[i]);
         end
      end
   endtask

   task automatic test_zoom_pan();
      run_cmd(0, 1, 0, "zoom_in");
      n_chk++;
      if (got.size() != 16 || got[0] !== 40 || got[15] !== 79) begin
         n_fail++;
         $display("FAIL zoom_in_ends: got %0d..%0d expected 40..79", got[0], got[got.size()-1]);
      end
      for (int i = 0; i < 5; i++) run_cmd(0, 3, 0, "right");
      n_chk++;
      if (got.size() != 16 || got[0] !== 44 || got[15] !== 83) begin
         n_fail++;
         $display("FAIL right_sat: got %0d..%0d expected 44..83", got[0], got[got.size()-1]);
      end
      for (int i = 0; i < 4; i++) run_cmd(0, 5, 0, "up");
      n_chk++;
      if (got.size() != 16 || got[0] !== 8) begin
         n_fail++;
         $display("FAIL up4: got %0d expected 8", got[0]);
      end
      run_cmd(0, 5, 0, "up_sat");
      n_chk++;
      if (got.size() != 16 || got[0] !== 8) begin
         n_fail++;
         $display("FAIL up_sat: got %0d expected 8", got[0]);
      end
      for (int i = 0; i < 7; i++) run_cmd(0, 6, 0, "down");
      n_chk++;
      if (got.size() != 16 || got[0] !== 68) begin
         n_fail++;
         $display("FAIL down_sat: got %0d expected 68", got[0]);
      end
   endtask

   task automatic test_mirror();
      int row_exp[4] = '{22, 19, 16, 13};
      run_cmd(0, 2, 0, "fit");
      run_cmd(0, 7, 0, "mirror_on");
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (got.size() != 16 || got[i] !== row_exp[i]) begin
            n_fail++;
            $display("FAIL mirror_row[%0d]: got %0d expected %0d", i, got[i], row_exp[i]);
         end
      end
      run_cmd(0, 7, 0, "mirror_off");
      n_chk++;
      if (got.size() != 16 || got[0] !== 13 || got[3] !== 22) begin
         n_fail++;
         $display("FAIL mirror_off: got %0d,%0d expected 13,22", got[0], got[3]);
      end
   endtask

   task automatic test_back_to_back();
      run_cmd(0, 1, 1, "noise_zin");
      for (int i = 0; i < 6; i++) run_cmd(0, $urandom_range(1, 7), 1, "noise_cmd");
   endtask

   task automatic test_random();
      for (int i = 0; i < W0 * H0; i++) img[0][i] = $urandom_range(0, 255);
      run_cmd(0, 0, 0, "load_rand");
      for (int i = 0; i < 40; i++) run_cmd(0, $urandom_range(1, 7), bit'($urandom_range(0, 1)), "rand_cmd");
   endtask

   task automatic test_geometry2();
      for (int i = 0; i < W1 * H1; i++) img[1][i] = i % 256;
      run_cmd(1, 0, 0, "g2_load");
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (got.size() != 64 || got[i] !== 17 + 2 * i) begin
            n_fail++;
            $display("FAIL g2_fit[%0d]: got %0d expected %0d", i, got[i], 17 + 2 * i);
         end
      end
      run_cmd(1, 1, 0, "g2_zin");
      n_chk++;
      if (got.size() != 64 || got[0] !== 68) begin
         n_fail++;
         $display("FAIL g2_zin: got %0d expected 68", got[0]);
      end
      for (int i = 0; i < 10; i++) run_cmd(1, $urandom_range(1, 7), 0, "g2_rand");
   endtask

   task automatic test_reset_mid_output();
      bit seen = 0;
      @(negedge clk);
      drive(0, 1'b1, 3'd2, 8'd0);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (ov0 === 1'b1) seen = 1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midrst_start: got no output_valid expected 1 within 20 cycles");
      end
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: got ov=%b busy=%b expected 0 0", ov0, busy0);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset(0);
      model_reset(1);
      run_cmd(0, 1, 0, "after_rst_zin");
      run_cmd(0, 2, 0, "after_rst_fit");
   endtask

   initial begin
      test_reset();
      test_no_load();
      test_load();
      test_zoom_pan();
      test_mirror();
      test_back_to_back();
      test_random();
      test_geometry2();
      test_reset_mid_output();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised image-window display controller and successor to the fixed 12x9 / 4x4 LCD controller.
- Loads an IMG_W x IMG_H raster of pixels into internal storage.
- On each command, streams a WIN x WIN view: either a subsampled "fit" view or a 1:1 zoomed window that can be panned.
- Adds a horizontal-mirror mode, saturating pan in any geometry, and defined behaviour before the first load.
- Sits between the pixel source and the LCD driver.

Parameters:
DW, 8, pixel data width
IMG_W, 12, image width in pixels (>= WIN)
IMG_H, 9, image height in pixels (>= WIN)
WIN, 4, output window side; each view is WIN*WIN pixels

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cmd  in  3  command code, sampled when accepted
cmd_valid  in  1  command strobe
datain  in  DW  pixel input during load
dataout  out  DW  pixel output
output_valid  out  1  dataout valid
busy  out  1  command in progress; commands ignored while high

Behaviour:
- Reset (async, active-high) values:
  - busy=0, output_valid=0, dataout=0.
  - State IDLE, mode=FIT, origin (ox,oy)=(0,0), mirror=0, loaded=0.
  - Pixel memory is not reset.
- Acceptance: a command is accepted on an edge where cmd_valid=1 and busy=0. busy=1 from that edge. cmd_valid while busy=1 is ignored with no side effects.
- Command codes:
  - 0 LOAD: datain is sampled on IMG_W*IMG_H consecutive edges starting the edge after acceptance, in raster order (row 0 col 0 first). Then loaded=1, mode=FIT, mirror=0, origin reset, and the FIT view is output.
  - 1 ZOOM_IN: mode=ZOOM; origin = ((IMG_W-WIN+1)/2, (IMG_H-WIN+1)/2) using integer division. The default geometry gives (4,3). Output the view.
  - 2 ZOOM_FIT: mode=FIT; output the view.
  - 3 RIGHT / 4 LEFT / 5 UP / 6 DOWN: in ZOOM mode, move the origin by 1 with saturation. ox is held in [0, IMG_W-WIN] and oy in [0, IMG_H-WIN]; at a limit the origin is unchanged but the view is still output. In FIT mode the command re-outputs the FIT view and the origin is untouched.
  - 7 MIRROR: toggle mirror; output the current view.
- View definitions (0-based coordinates):
  - ZOOM view: pixel (ox+c, oy+r).
  - FIT view: pixel (SX/2 + c*SX, SY/2 + r*SY), where SX = IMG_W/WIN and SY = IMG_H/WIN (integer division).
  - Output order: r = 0..WIN-1 outer loop, c inner loop. With mirror=1, c runs WIN-1 down to 0.
- Timing:
  - For a non-load command accepted at edge T: one compute cycle, then output_valid=1 for exactly WIN*WIN consecutive edges, T+2 through T+1+WIN*WIN.
  - On edge T+2+WIN*WIN: output_valid=0 and busy=0. A new command can be accepted on the following edge.
  - LOAD: last pixel sampled at edge T+IMG_W*IMG_H. Output follows with the same compute-cycle timing as above.
- Before the first LOAD (loaded=0): non-load commands are accepted and update mode/origin/mirror, but produce no output. busy is high for exactly one cycle.
- dataout holds its last value when output_valid=0.
- Address arithmetic: memory index = y*IMG_W + x, computed with width clog2(IMG_W*IMG_H). Counters must be sized from the parameters, with no overflow at the maximum counts.
- Reset asserted mid-load or mid-output aborts immediately. After reset, LOAD must be reissued before views are output.

Test Plan:
- Default params, LOAD with datain = 0..107 -> 16 outputs starting two cycles after the last load pixel: 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy drops the edge after 94.
- ZOOM_IN -> 40,41,42,43,52..55,64..67,76..79. Then RIGHT x5 -> origin saturates at x=8 after 4 steps; the 5th output's first pixel is 44 and last is 83.
- From origin (8,3), UP x4 -> 4th view starts at 8; a 5th UP repeats the view starting at 8. DOWN x7 -> final view starts 8+5*12=68 (oy saturates at 5).
- MIRROR in FIT mode -> first row 22,19,16,13; MIRROR again -> normal order restored. cmd_valid pulses during busy -> no change to the output stream.
- Reset power-up, ZOOM_IN before any LOAD -> busy high one cycle, output_valid never asserts. Assert reset mid-output -> output_valid=0 and busy=0 immediately (asynchronous).
- Params IMG_W=16, IMG_H=16, WIN=8, datain = index mod 256 -> FIT view first row 17,19,...,31 (SX=SY=2). ZOOM_IN first pixel 4*16+4=68.
